time_field_counter: RTL and testbench

//   Parametrised modulo counter for one clock-display time field (hours, minutes, seconds).

---
 rtl/time_field_counter.sv | 174 +++++++++++++++++
 tb/tb_time_field_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_field_counter.sv
// time_field_counter
// Modulo counter for one clock-display time field (hours, minutes or seconds).
// Counts up or down, accepts range-checked synchronous loads, and produces
// registered carry/borrow pulses so that instances can be chained: the
// carryOut of the seconds field drives tickEn of the minutes field, and so on.
// The binary count is registered. The BCD digits and the AM/PM flag are
// decoded combinationally from the count, so they add no latency.

module time_field_counter #(
    parameter int WIDTH       = 5,
    parameter int MODULUS     = 24,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tickEn,
    input  logic             countDown,
    input  logic             loadEn,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             mode12,
    output logic [WIDTH-1:0] outValue,
    output logic [3:0]       outTens,
    output logic [3:0]       outOnes,
    output logic             outPm,
    output logic             carryOut,
    output logic             borrowOut,
    output logic             loadErr
);

    // ------------------------------------------------------------------
    // Parameter sanity checks, reported at elaboration time
    // ------------------------------------------------------------------
    if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
        $error("time_field_counter: RESET_VALUE (%0d) must be below MODULUS (%0d)",
               RESET_VALUE, MODULUS);
    end
    if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
        $error("time_field_counter: WIDTH (%0d) too small for MODULUS (%0d)",
               WIDTH, MODULUS);
    end
    if ((MODULUS < 2) || (MODULUS > 99)) begin : g_bad_modulus
        $error("time_field_counter: MODULUS (%0d) outside 2..99", MODULUS);
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // The 12-hour view only makes sense for a 24-hour field.
    localparam bit               IS_24   = (MODULUS == 24);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]   MOD_C   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Binary (0..99) to two BCD digits. The value is reduced by repeated
    // subtraction of ten: nine compare/subtract stages cover the full
    // range and stay cheap as combinational logic.
    function automatic logic [7:0] bin2bcd(input logic [6:0] value);
        logic [3:0] tens;
        logic [6:0] rest;
        tens = 4'd0;
        rest = value;
        for (int i = 0; i < 9; i++) begin
            if (rest >= 7'd10) begin
                rest = rest - 7'd10;
                tens = tens + 4'd1;
            end else begin
                rest = rest;
                tens = tens;
            end
        end
        return {tens, rest[3:0]};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] value_q,  value_d;
    logic             carry_q,  carry_d;
    logic             borrow_q, borrow_d;
    logic             err_q,    err_d;

    // Display path
    logic             load_ok_s;
    logic [6:0]       count7_s;
    logic [6:0]       disp_s;
    logic [7:0]       bcd_s;

    // A load is accepted only when the requested value is inside the range.
    assign load_ok_s = ({1'b0, loadValue} < MOD_C);

    // Next-state logic. Priority is load, then tick, then hold; reset is
    // applied in the register process. Pulse outputs default to low, so each
    // pulse lasts exactly one cycle unless the next cycle wraps again.
    always_comb begin
        value_d  = value_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        if (loadEn) begin
            if (load_ok_s) begin
                value_d = loadValue;
            end else begin
                err_d   = 1'b1;
            end
        end else if (tickEn) begin
            if (countDown) begin
                if (value_q == {WIDTH{1'b0}}) begin
                    value_d  = MAX_C;
                    borrow_d = 1'b1;
                end else begin
                    value_d  = value_q - ONE_C;
                end
            end else begin
                if (value_q == MAX_C) begin
                    value_d = {WIDTH{1'b0}};
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q + ONE_C;
                end
            end
        end else begin
            value_d = value_q;
        end
    end

    // Count and pulse registers with a synchronous active-high reset that
    // overrides any load or tick in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q  <= RESET_C;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            value_q  <= value_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    // Display value. In 12-hour mode a 24-hour count maps 0 to 12 and
    // 13..23 to 1..11. mode12 only affects this view, never the count.
    always_comb begin
        count7_s = 7'(value_q);
        disp_s   = count7_s;
        if (mode12 && IS_24) begin
            if (count7_s == 7'd0) begin
                disp_s = 7'd12;
            end else if (count7_s > 7'd12) begin
                disp_s = count7_s - 7'd12;
            end else begin
                disp_s = count7_s;
            end
        end else begin
            disp_s = count7_s;
        end
    end

    assign bcd_s     = bin2bcd(disp_s);

    assign outValue  = value_q;
    assign outTens   = bcd_s[7:4];
    assign outOnes   = bcd_s[3:0];
    assign outPm     = IS_24 && (count7_s >= 7'd12);
    assign carryOut  = carry_q;
    assign borrowOut = borrow_q;
    assign loadErr   = err_q;

endmodule

// File: tb/tb_time_field_counter.sv
// Directed testbench for time_field_counter. It uses a 24-hour instance, a
// 60-count instance, a modulo-2 instance and a seconds/minutes/hours chain.
module tb_time_field_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 24-hour instance
    logic       t24 = 1'b0, d24 = 1'b0, l24 = 1'b0, m12 = 1'b0;
    logic [4:0] lv24 = 5'd0;
    logic [4:0] o24;
    logic [3:0] tn24, on24;
    logic       pm24, c24, b24, e24;

    // 60-count instance
    logic       t60 = 1'b0, d60 = 1'b0, l60 = 1'b0;
    logic [5:0] lv60 = 6'd0;
    logic [5:0] o60;
    logic [3:0] tn60, on60;
    logic       pm60, c60, b60, e60;

    // Modulo-2 instance
    logic       t2 = 1'b0, d2 = 1'b0, l2 = 1'b0;
    logic [0:0] lv2 = 1'b0;
    logic [0:0] o2;
    logic [3:0] tn2, on2;
    logic       pm2, c2, b2, e2;

    // Chain: seconds -> minutes -> hours
    logic       tsec = 1'b0, lch = 1'b0;
    logic [5:0] lvs = 6'd0, lvm = 6'd0;
    logic [4:0] lvh = 5'd0;
    logic [5:0] os, om;
    logic [4:0] oh;
    logic [3:0] tns, ons, tnm, onm, tnh, onh;
    logic       pms, pmm, pmh, cs, cm, ch, bs, bm, bh, es, em, eh;

    time_field_counter #(.WIDTH(5), .MODULUS(24), .RESET_VALUE(0)) u24 (
        .clk(clk), .reset(reset), .tickEn(t24), .countDown(d24), .loadEn(l24),
        .loadValue(lv24), .mode12(m12), .outValue(o24), .outTens(tn24), .outOnes(on24),
        .outPm(pm24), .carryOut(c24), .borrowOut(b24), .loadErr(e24));

    time_field_counter #(.WIDTH(6), .MODULUS(60), .RESET_VALUE(0)) u60 (
        .clk(clk), .reset(reset), .tickEn(t60), .countDown(d60), .loadEn(l60),
        .loadValue(lv60), .mode12(m12), .outValue(o60), .outTens(tn60), .outOnes(on60),
        .outPm(pm60), .carryOut(c60), .borrowOut(b60), .loadErr(e60));

    time_field_counter #(.WIDTH(1), .MODULUS(2), .RESET_VALUE(0)) u2 (
        .clk(clk), .reset(reset), .tickEn(t2), .countDown(d2), .loadEn(l2),
        .loadValue(lv2), .mode12(1'b0), .outValue(o2), .outTens(tn2), .outOnes(on2),
        .outPm(pm2), .carryOut(c2), .borrowOut(b2), .loadErr(e2));

    time_field_counter #(.WIDTH(6), .MODULUS(60), .RESET_VALUE(0)) u_sec (
        .clk(clk), .reset(reset), .tickEn(tsec), .countDown(1'b0), .loadEn(lch),
        .loadValue(lvs), .mode12(1'b0), .outValue(os), .outTens(tns), .outOnes(ons),
        .outPm(pms), .carryOut(cs), .borrowOut(bs), .loadErr(es));

    time_field_counter #(.WIDTH(6), .MODULUS(60), .RESET_VALUE(0)) u_min (
        .clk(clk), .reset(reset), .tickEn(cs), .countDown(1'b0), .loadEn(lch),
        .loadValue(lvm), .mode12(1'b0), .outValue(om), .outTens(tnm), .outOnes(onm),
        .outPm(pmm), .carryOut(cm), .borrowOut(bm), .loadErr(em));

    time_field_counter #(.WIDTH(5), .MODULUS(24), .RESET_VALUE(0)) u_hr (
        .clk(clk), .reset(reset), .tickEn(cm), .countDown(1'b0), .loadEn(lch),
        .loadValue(lvh), .mode12(1'b0), .outValue(oh), .outTens(tnh), .outOnes(onh),
        .outPm(pmh), .carryOut(ch), .borrowOut(bh), .loadErr(eh));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        checks++; if (o24 !== 5'd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", o24); end
        checks++; if ({c24, b24, e24} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {c24, b24, e24}); end
        checks++; if ({tn24, on24, pm24} !== 9'd0) begin failures++; $display("FAIL reset_decode got=%0d/%0d/%0d exp=0/0/0", tn24, on24, pm24); end
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        int exp_v;
        t24 = 1'b1; d24 = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            exp_v = i % 24;
            checks++; if (o24 !== 5'(exp_v)) begin failures++; $display("FAIL up_value step=%0d got=%0d exp=%0d", i, o24, exp_v); end
            checks++; if (c24 !== (i == 24)) begin failures++; $display("FAIL up_carry step=%0d got=%0d exp=%0d", i, c24, (i == 24)); end
            checks++; if ({tn24, on24} !== {4'(exp_v / 10), 4'(exp_v % 10)}) begin failures++; $display("FAIL up_bcd step=%0d got=%0d/%0d exp=%0d/%0d", i, tn24, on24, exp_v / 10, exp_v % 10); end
        end
        t24 = 1'b0;
        cyc();
        checks++; if ({o24, c24} !== {5'd0, 1'b0}) begin failures++; $display("FAIL up_hold got=%0d/%0d exp=0/0", o24, c24); end
    endtask

    task automatic test_borrow();
        l60 = 1'b1; lv60 = 6'd0;
        cyc();
        l60 = 1'b0;
        checks++; if (o60 !== 6'd0) begin failures++; $display("FAIL bor_load got=%0d exp=0", o60); end
        t60 = 1'b1; d60 = 1'b1;
        cyc();
        checks++; if (o60 !== 6'd59) begin failures++; $display("FAIL bor_value got=%0d exp=59", o60); end
        checks++; if ({b60, c60} !== 2'b10) begin failures++; $display("FAIL bor_pulse got=%b exp=10", {b60, c60}); end
        checks++; if ({tn60, on60} !== {4'd5, 4'd9}) begin failures++; $display("FAIL bor_bcd got=%0d/%0d exp=5/9", tn60, on60); end
        cyc();
        checks++; if ({o60, b60} !== {6'd58, 1'b0}) begin failures++; $display("FAIL bor_next got=%0d/%0d exp=58/0", o60, b60); end
        t60 = 1'b0; d60 = 1'b0;
        cyc();
        checks++; if ({o60, b60} !== {6'd58, 1'b0}) begin failures++; $display("FAIL bor_hold got=%0d/%0d exp=58/0", o60, b60); end
    endtask

    task automatic test_load_err();
        l24 = 1'b1; lv24 = 5'd24; t24 = 1'b1;
        cyc();
        l24 = 1'b0; t24 = 1'b0;
        checks++; if ({o24, e24, c24} !== {5'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL lerr_24 got=%0d/%0d/%0d exp=0/1/0", o24, e24, c24); end
        cyc();
        checks++; if ({o24, e24} !== {5'd0, 1'b0}) begin failures++; $display("FAIL lerr_clear got=%0d/%0d exp=0/0", o24, e24); end
        l24 = 1'b1; lv24 = 5'd17;
        cyc();
        l24 = 1'b0;
        checks++; if ({o24, e24} !== {5'd17, 1'b0}) begin failures++; $display("FAIL load_17 got=%0d/%0d exp=17/0", o24, e24); end
        l24 = 1'b1; lv24 = 5'd31;
        cyc();
        l24 = 1'b0;
        checks++; if ({o24, e24} !== {5'd17, 1'b1}) begin failures++; $display("FAIL lerr_31 got=%0d/%0d exp=17/1", o24, e24); end
    endtask

    task automatic test_mode12();
        logic [4:0] vals [5] = '{5'd0, 5'd1, 5'd12, 5'd13, 5'd23};
        logic [3:0] etn  [5] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
        logic [3:0] eon  [5] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd1};
        logic       epm  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        m12 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            l24 = 1'b1; lv24 = vals[i];
            cyc();
            l24 = 1'b0;
            checks++; if ({o24, tn24, on24, pm24} !== {vals[i], etn[i], eon[i], epm[i]})
                begin failures++; $display("FAIL m12_sweep v=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", vals[i], tn24, on24, pm24, etn[i], eon[i], epm[i]); end
        end
        checks++; if ({tn60, on60, pm60} !== {4'd5, 4'd8, 1'b0}) begin failures++; $display("FAIL m12_mod60 got=%0d/%0d/%0d exp=5/8/0", tn60, on60, pm60); end
        m12 = 1'b0;
        #1;
        checks++; if ({o24, tn24, on24, pm24} !== {5'd23, 4'd2, 4'd3, 1'b1}) begin failures++; $display("FAIL m12_off got=%0d %0d/%0d/%0d exp=23 2/3/1", o24, tn24, on24, pm24); end
        cyc();
        checks++; if (o24 !== 5'd23) begin failures++; $display("FAIL m12_count got=%0d exp=23", o24); end
        m12 = 1'b1;
        #1;
        checks++; if ({o24, tn24, on24} !== {5'd23, 4'd1, 4'd1}) begin failures++; $display("FAIL m12_on got=%0d %0d/%0d exp=23 1/1", o24, tn24, on24); end
        m12 = 1'b0;
    endtask

    task automatic test_priority();
        l24 = 1'b1; lv24 = 5'd10;
        cyc();
        reset = 1'b1; l24 = 1'b1; lv24 = 5'd7; t24 = 1'b1;
        cyc();
        checks++; if ({o24, c24, b24, e24} !== {5'd0, 3'b000}) begin failures++; $display("FAIL prio_load got=%0d/%b exp=0/000", o24, {c24, b24, e24}); end
        l24 = 1'b0; d24 = 1'b1;
        cyc();
        checks++; if ({o24, b24} !== {5'd0, 1'b0}) begin failures++; $display("FAIL prio_tick got=%0d/%0d exp=0/0", o24, b24); end
        l24 = 1'b1; lv24 = 5'd30;
        cyc();
        checks++; if ({o24, e24} !== {5'd0, 1'b0}) begin failures++; $display("FAIL prio_err got=%0d/%0d exp=0/0", o24, e24); end
        reset = 1'b0; lv24 = 5'd5; d24 = 1'b0;
        cyc();
        l24 = 1'b0; t24 = 1'b0;
        checks++; if ({o24, c24, e24} !== {5'd5, 2'b00}) begin failures++; $display("FAIL prio_ld5 got=%0d/%b exp=5/00", o24, {c24, e24}); end
    endtask

    task automatic test_back_to_back();
        l2 = 1'b1; lv2 = 1'b1;
        cyc();
        l2 = 1'b0; t2 = 1'b1; d2 = 1'b0;
        cyc();
        checks++; if ({o2, c2, b2} !== 3'b010) begin failures++; $display("FAIL b2b_up1 got=%b exp=010", {o2, c2, b2}); end
        d2 = 1'b1;
        cyc();
        checks++; if ({o2, c2, b2} !== 3'b101) begin failures++; $display("FAIL b2b_dn got=%b exp=101", {o2, c2, b2}); end
        d2 = 1'b0;
        cyc();
        checks++; if ({o2, c2, b2} !== 3'b010) begin failures++; $display("FAIL b2b_up2 got=%b exp=010", {o2, c2, b2}); end
        t2 = 1'b0;
        cyc();
        checks++; if ({o2, c2, b2} !== 3'b000) begin failures++; $display("FAIL b2b_idle got=%b exp=000", {o2, c2, b2}); end
    endtask

    task automatic test_chain();
        lch = 1'b1; lvs = 6'd59; lvm = 6'd59; lvh = 5'd23;
        cyc();
        lch = 1'b0;
        checks++; if ({oh, om, os} !== {5'd23, 6'd59, 6'd59}) begin failures++; $display("FAIL chain_load got=%0d:%0d:%0d exp=23:59:59", oh, om, os); end
        tsec = 1'b1;
        cyc();
        tsec = 1'b0;
        checks++; if ({oh, om, os, ch, cm, cs} !== {5'd23, 6'd59, 6'd0, 3'b001}) begin failures++; $display("FAIL chain_c1 got=%0d:%0d:%0d c=%b exp=23:59:0 c=001", oh, om, os, {ch, cm, cs}); end
        cyc();
        checks++; if ({oh, om, os, ch, cm, cs} !== {5'd23, 6'd0, 6'd0, 3'b010}) begin failures++; $display("FAIL chain_c2 got=%0d:%0d:%0d c=%b exp=23:0:0 c=010", oh, om, os, {ch, cm, cs}); end
        cyc();
        checks++; if ({oh, om, os, ch, cm, cs} !== {5'd0, 6'd0, 6'd0, 3'b100}) begin failures++; $display("FAIL chain_c3 got=%0d:%0d:%0d c=%b exp=0:0:0 c=100", oh, om, os, {ch, cm, cs}); end
        cyc();
        checks++; if ({oh, om, os, ch, cm, cs} !== {5'd0, 6'd0, 6'd0, 3'b000}) begin failures++; $display("FAIL chain_end got=%0d:%0d:%0d c=%b exp=0:0:0 c=000", oh, om, os, {ch, cm, cs}); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_borrow();
        test_load_err();
        test_mode12();
        test_priority();
        test_back_to_back();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
